// File: rtl/apb_pkg.sv
// Shared types and address-decode helpers for the wait-state APB completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2
   } state_e;

   localparam int unsigned WAIT_W = 4;

   // WAIT_CFG lives at the all-ones offset of the completer's address space.
   function automatic logic [31:0] wait_cfg_offset(input int unsigned aw);
      return (32'd1 << aw) - 32'd1;
   endfunction

   function automatic logic addr_err(input logic [31:0] offset,
                                     input int unsigned depth,
                                     input int unsigned aw);
      logic [31:0] cfg_off;
      cfg_off = wait_cfg_offset(aw);
      return (offset >= depth) && (offset != cfg_off);
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Down-counter for access-phase wait states; flags zero when the wait has elapsed.
module apb_wait_counter
   import apb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_val,
   input  logic              en,
   output logic              zero
);

   logic [WAIT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_waitstate_slave.sv
// APB completer with a DEPTH-entry register array, programmable wait states
// (WAIT_CFG at the all-ones offset) and PSLVERR on unmapped offsets.
module apb_waitstate_slave
   import apb_pkg::*;
#(
   parameter int unsigned DATAWIDTH    = 8,
   parameter int unsigned ADDRWIDTH    = 8,
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned WAIT_DEFAULT = 0
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [ADDRWIDTH:0]   PADDR,
   input  logic [DATAWIDTH-1:0] PWDATA,
   output logic [DATAWIDTH-1:0] PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR
);

   localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRWIDTH-1:0] CFG_OFF = ADDRWIDTH'(wait_cfg_offset(ADDRWIDTH));

   state_e                 state_q, state_d;
   logic [ADDRWIDTH-1:0]   off_q, off_d;
   logic                   write_q, write_d;
   logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
   logic                   err_q, err_d;
   logic [WAIT_W-1:0]      wait_cfg_q, wait_cfg_d;
   logic [DATAWIDTH-1:0]   mem_q [DEPTH];
   logic [DATAWIDTH-1:0]   mem_d [DEPTH];
   logic [DATAWIDTH-1:0]   prdata_q, prdata_d;
   logic                   pready_q, pready_d;
   logic                   pslverr_q, pslverr_d;

   logic                   setup;
   logic                   cnt_load, cnt_en, cnt_zero;
   logic [WAIT_W-1:0]      cnt_load_val;
   logic [IDXW-1:0]        idx_q, idx_d;
   logic                   unused_paddr_msb;

   assign setup            = PSEL && !PENABLE;
   assign unused_paddr_msb = PADDR[ADDRWIDTH];
   assign idx_q            = off_q[IDXW-1:0];
   assign idx_d            = off_d[IDXW-1:0];

   assign cnt_load     = (state_q == IDLE) && setup && (wait_cfg_q != '0);
   assign cnt_load_val = wait_cfg_q - WAIT_W'(1);
   assign cnt_en       = (state_q == WAIT) && PSEL && !cnt_zero;

   apb_wait_counter u_wait_counter (
      .clk      (PCLK),
      .rst      (PRESET),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= IDLE;
         off_q      <= '0;
         write_q    <= 1'b0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         wait_cfg_q <= WAIT_W'(WAIT_DEFAULT);
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         prdata_q   <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         write_q    <= write_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         wait_cfg_q <= wait_cfg_d;
         mem_q      <= mem_d;
         prdata_q   <= prdata_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               state_d = (wait_cfg_q == '0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            if (!PSEL) begin
               state_d = IDLE;
            end else if (cnt_zero) begin
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      off_d      = off_q;
      write_d    = write_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      wait_cfg_d = wait_cfg_q;
      mem_d      = mem_q;
      if ((state_q == IDLE) && setup) begin
         off_d   = PADDR[ADDRWIDTH-1:0];
         write_d = PWRITE;
         wdata_d = PWDATA;
         err_d   = addr_err(32'(PADDR[ADDRWIDTH-1:0]), DEPTH, ADDRWIDTH);
      end
      // Commit only if the master still holds the access phase at the end of ACCESS.
      if ((state_q == ACCESS) && PSEL && PENABLE && write_q && !err_q) begin
         if (off_q == CFG_OFF) begin
            wait_cfg_d = wdata_q[WAIT_W-1:0];
         end else begin
            mem_d[idx_q] = wdata_q;
         end
      end
   end

   always_comb begin
      pready_d  = (state_d == ACCESS);
      pslverr_d = pready_d && err_d;
      prdata_d  = prdata_q;
      if (pready_d && !write_d) begin
         if (err_d) begin
            prdata_d = '0;
         end else if (off_d == CFG_OFF) begin
            prdata_d = DATAWIDTH'(wait_cfg_q);
         end else begin
            prdata_d = mem_q[idx_d];
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: doc/apb_waitstate_slave.md
# apb_waitstate_slave

APB completer that sits downstream of the APB master bridge. It receives one slave-select and the shared PADDR/PWDATA/PWRITE/PENABLE bus, and serves a DEPTH-entry register array. It adds a programmable wait-state counter and PSLVERR generation on top of the zero-wait slaves. The bus-level decode of PADDR[ADDRWIDTH] is done upstream; this block sees only its own PSEL.

## Interface
- DATAWIDTH, 8, data bus width
- ADDRWIDTH, 8, offset width (PADDR is ADDRWIDTH+1 bits, top bit ignored here)
- DEPTH, 64, storage entries at offsets 0..DEPTH-1 (DEPTH ≤ 255)
- WAIT_DEFAULT, 0, reset value of wait-state register (0..15)

- PCLK  input  1  clock; one clock, all logic on rising edge
- PRESET  input  1  reset, synchronous, active-high
- PSEL  input  1  slave select
- PENABLE  input  1  access phase
- PWRITE  input  1  1 = write, 0 = read
- PADDR  input  ADDRWIDTH+1  address; bits [ADDRWIDTH-1:0] used
- PWDATA  input  DATAWIDTH  write data
- PRDATA  output  DATAWIDTH  read data, registered
- PREADY  output  1  transfer completes this cycle, registered
- PSLVERR  output  1  error, valid only with PREADY

## Operation
- Address map:
  - Offsets 0..DEPTH-1: storage.
  - Offset all-ones (0xFF at default width): WAIT_CFG, with wait count in low 4 bits; reads return zero-extended value.
  - Any other offset: error.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - On PSEL=1 and PENABLE=0 (setup phase), capture offset, PWRITE and PWDATA, and compute err.
  - Go to ACCESS if wait_cfg==0; otherwise go to WAIT with cnt=wait_cfg-1.
  - PENABLE=1 without a preceding setup phase is ignored.
- WAIT: if PSEL=0, go to IDLE (abort). If cnt==0, go to ACCESS; otherwise decrement cnt.
- ACCESS:
  - PREADY=1 and PSLVERR=err.
  - For reads, PRDATA is loaded on entry: array[offset], WAIT_CFG, or 0 on err.
  - A write commits at the end of the ACCESS cycle if PSEL and PENABLE are high and err=0.
  - Next state is IDLE. IDLE samples the next setup phase in the same cycle, so back-to-back transfers need no dead cycle.
- A write to WAIT_CFG takes effect from the next transfer's setup phase.
- A read with err=1 returns PRDATA=0. A write with err=1 leaves all state unchanged.

## Timing
- Reset (synchronous):
  - State=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, cnt=0.
  - wait_cfg=WAIT_DEFAULT; all array entries cleared to 0.
- Reset asserted mid-transfer: the transfer is dropped, no write commits, and outputs take reset values on the next edge.
- Cycle numbering: T0 = setup (PSEL=1, PENABLE=0), T1 = first PENABLE cycle.
  - With W = wait_cfg, PREADY is high in cycle T1+W only, for exactly one cycle.
- Write data is visible to a read whose setup phase is the cycle after the write's ACCESS cycle.
- PRDATA holds its last loaded value outside ACCESS. PSLVERR is 0 whenever PREADY=0.
- PSEL dropping in WAIT or ACCESS: no PREADY is issued afterwards and no write commits.

## Structure
- Shared package apb_pkg holds:
  - state enum {IDLE, WAIT, ACCESS}
  - WAIT_W=4
  - WAIT_CFG_OFFSET (all-ones of ADDRWIDTH)
  - error-decode function (offset ≥ DEPTH and offset ≠ WAIT_CFG_OFFSET)
- One sub-module, apb_wait_counter:
  - Inputs: load, load value, enable.
  - Output: zero flag.
  - Instantiated once.
- The FSM, array and output registers stay in the top module.

## Test plan
- Reset, wait=0: write 0x5A to 0x10, then read 0x10. Each transfer gets PREADY in T1 with PSLVERR=0, and the read returns PRDATA=0x5A.
- Write 0x03 to 0xFF, then write 0xA5 to 0x03. The second transfer gets PREADY in T4 only. Reading 0xFF returns 0x03; reading 0x03 returns 0xA5.
- DEPTH=64: write 0x77 to 0x40 gives PREADY with PSLVERR=1. Reading 0x40 gives PRDATA=0 and PSLVERR=1. Reading 0x00 then gives 0x00 with PSLVERR=0.
- Back-to-back transfers: write 0x11 to 0x01 with the read-of-0x01 setup in the very next cycle. The read returns 0x11 with no idle cycle inserted.
- Wait=5, write 0xEE to 0x02, drop PSEL in the 2nd WAIT cycle: PREADY never rises and a read of 0x02 returns 0x00.
- Repeat with PRESET pulsed mid-WAIT instead of dropping PSEL: outputs are 0 on the next edge and WAIT_CFG reads back as WAIT_DEFAULT.
